i2c_tx_fifo: RTL
================

# i2c_tx_fifo

Byte-wide transmit buffer between the host-side register interface and the I2C master engine. The host pushes payload bytes; the master pops one byte per `i_txff_rd` strobe and sees the current head byte on `data_in` in first-word-fall-through (FWFT) fashion. The block turns the master's multi-cycle, `sclk`-qualified level strobe into exactly one pop per strobe, and reports occupancy and error status back to the host.

## Interface
- `DEPTH`, 16: entries; power of two, 2..256.
- `AW`, 4: log2(`DEPTH`); pointer width.
- `AFULL_TH`, 12: `almost_full` asserts when `count >= AFULL_TH`; range 1..`DEPTH`.
- `clk` in 1: system clock, the same clock that feeds the master's clock divider.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: host push request.
- `wr_data` in 8: host push byte.
- `i_txff_rd` in 1: pop strobe from the I2C master. It is a level signal and may stay high for many `clk` cycles.
- `err_clr` in 1: clears the sticky error flags.
- `data_in` out 8: head byte, driven to the master's `data_in`.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: `count == DEPTH`.
- `almost_full` out 1: `count >= AFULL_TH`.
- `count` out AW+1: number of stored entries, 0..`DEPTH`.
- `ovf` out 1: sticky flag, push attempted while full.
- `udf` out 1: sticky flag, pop edge seen while empty.

## Operation
- Storage: `DEPTH` x 8 register array, write pointer `wp` and read pointer `rp` (each AW bits, wrap modulo `DEPTH`), plus an explicit AW+1-bit `count`.
- Push: `wr_en & ~full` writes `wr_data` to `mem[wp]` and increments `wp`. `wr_en & full` is dropped with no state change except `ovf`.
- Strobe conditioning: registers `rd_s1 <= i_txff_rd` and `rd_s2 <= rd_s1`. `rd_edge = rd_s1 & ~rd_s2`.
- Pop: `rd_edge & ~empty` increments `rp`. `rd_edge & empty` is ignored except for `udf`. A strobe held high produces exactly one pop.
- Simultaneous push and pop (both accepted): both pointers advance and `count` is unchanged.
- `full` is evaluated on the pre-edge state. A push while full is rejected even if a pop happens in the same cycle.
- When empty, a push and a `rd_edge` in the same cycle: the push is accepted, the pop is ignored, and `udf` is set.
- `count` increments on push-only and decrements on pop-only. It never exceeds `DEPTH` or goes below 0.
- `data_in = empty ? 8'h00 : mem[rp]`. This is combinational from registers; no read latency.
- `empty = (count == 0)`. `full`, `almost_full`, and `empty` are all derived from `count`.
- Error flags: set on the event and held until `err_clr`. If a set event and `err_clr` occur in the same cycle, set wins.

## Timing
- Reset values (all outputs and state):
  - `wp = rp = 0`, `count = 0`
  - `empty = 1`, `full = 0`, `almost_full = 0`
  - `data_in = 8'h00`
  - `ovf = udf = 0`
  - `rd_s1 = rd_s2 = 1`
- Because `rd_s1`/`rd_s2` reset to 1, a strobe held high across reset causes no pop. The first pop after reset requires `i_txff_rd` to go low and then high again.
- Reset mid-operation discards all contents; memory contents are not cleared. Reset has priority over push, pop, and `err_clr`.
- Push latency: with `wr_en` sampled at edge N, `count`, `empty`, and `data_in` (if the FIFO was empty) update after edge N.
- Pop latency: with `i_txff_rd` first sampled high at edge N, `rd_edge` is high during cycle N..N+1, `rp` advances at edge N+1, and the new head is visible on `data_in` after edge N+1.
- The master holds `i_txff_rd` for at least one full `clk` cycle, so it is always captured.
- Minimum spacing between pops: `i_txff_rd` low for ≥1 `clk` cycle between strobes.

## Configuration
- `I2C_TXFF_ERR_EN` defined: `ovf`/`udf` sticky logic and `err_clr` handling are compiled in as described above.
- `I2C_TXFF_ERR_EN` undefined:
  - `ovf` and `udf` are tied to 0 and `err_clr` is ignored.
  - Dropped pushes and ignored pops are silent.
  - All other behaviour is identical.

## Test plan
- Reset, push 8'hA5 then 8'h3C → `data_in = A5` and `count = 2` after the second edge. Pulse `i_txff_rd` high for 5 cycles → exactly one pop, `data_in = 3C`, `count = 1` two edges after the strobe rises.
- Push 16 bytes 8'h00..8'h0F → `full = 1`, `almost_full` asserts at `count = 12`. A 17th push is dropped, `ovf = 1`, `count = 16`, and `data_in` stays `00`. Pop 16 times → bytes 00..0F come out in order and pointers wrap to 0.
- FIFO empty, strobe `i_txff_rd` → `udf = 1`, `count = 0`, `data_in = 00`. Assert `err_clr` → `udf = 0`. `err_clr` coincident with a new underflow edge → `udf` stays 1.
- With `count = 5`, a push in the same cycle as `rd_edge` → `count` stays 5 and the head advances by one entry.
- Hold `i_txff_rd` high, pulse `rst` → `count = 0`, `empty = 1`, and no pop occurs while the strobe stays high. Drop the strobe, push 8'h77, raise the strobe → one pop, `empty = 1`.
- Build without `I2C_TXFF_ERR_EN`, repeat the overflow and underflow cases → `ovf = udf = 0` throughout, all other responses unchanged.

Source files
------------

// File: rtl/i2c_tx_fifo_if.sv
// Host/master-engine side bundle for the I2C transmit FIFO.
// master = driver of push/pop/clear, slave = the FIFO itself.
interface i2c_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          i_txff_rd;
  logic          err_clr;
  logic [7:0]    data_in;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  modport master (
    output wr_en, wr_data, i_txff_rd, err_clr,
    input  data_in, empty, full, almost_full, count, ovf, udf
  );

  modport slave (
    input  wr_en, wr_data, i_txff_rd, err_clr,
    output data_in, empty, full, almost_full, count, ovf, udf
  );
endinterface

// File: rtl/i2c_tx_fifo.sv
// FWFT byte FIFO feeding the I2C master; one pop per rising edge of the level strobe.
// Optional sticky ovf/udf error flags are compiled in with `define I2C_TXFF_ERR_EN.
module i2c_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AFULL_TH = 12
) (
  input logic            clk,
  input logic            rst,
  i2c_tx_fifo_if.slave   bus
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL_TH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_rd_s1;
  logic          r_rd_s2;

  logic w_rd_edge;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_rd_edge = r_rd_s1 & ~r_rd_s2;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_push    = bus.wr_en & ~w_full;
  assign w_pop     = w_rd_edge & ~w_empty;

  // Storage is deliberately left out of reset; contents are invalidated by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= bus.wr_data;
    end
  end

  // Strobe history resets high so a strobe held across reset cannot pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_rd_s1 <= 1'b1;
      r_rd_s2 <= 1'b1;
    end else begin
      r_rd_s1 <= bus.i_txff_rd;
      r_rd_s2 <= r_rd_s1;
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef I2C_TXFF_ERR_EN
  logic r_ovf;
  logic r_udf;

  // A set event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.wr_en & w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.err_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_rd_edge & w_empty) begin
        r_udf <= 1'b1;
      end else if (bus.err_clr) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.data_in     = w_empty ? 8'h00 : r_mem[r_rp];
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = (r_count >= LP_AFULL);
  assign bus.count       = r_count;
endmodule
